// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: width codes, write strobes, FSM states
// and request decode helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] WE_NONE = 3'b000;
  localparam logic [2:0] WE_WORD = 3'b001;
  localparam logic [2:0] WE_HALF = 3'b010;
  localparam logic [2:0] WE_BYTE = 3'b100;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } state_e;

  // Reserved width codes and unsigned stores are rejected like misaligned accesses.
  function automatic logic is_bad_req(input logic store, input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
    logic bad;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = addr_lo[0];
      F3_W:    bad = (addr_lo != 2'b00);
      F3_BU:   bad = store;
      F3_HU:   bad = store | addr_lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [2:0] we_code(input logic [2:0] funct3);
    logic [2:0] we;
    case (funct3)
      F3_B, F3_BU: we = WE_BYTE;
      F3_H, F3_HU: we = WE_HALF;
      default:     we = WE_WORD;
    endcase
    return we;
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Sign/zero extension of RAM read data according to the RV32I load width code.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] result
);

  always_comb begin
    result = raw;
    case (funct3)
      F3_B:    result = {{24{raw[7]}}, raw[7:0]};
      F3_BU:   result = {24'd0, raw[7:0]};
      F3_H:    result = {{16{raw[15]}}, raw[15:0]};
      F3_HU:   result = {16'd0, raw[15:0]};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding access, IDLE -> ISSUE -> (WAIT) -> RESP, with
// misaligned or reserved requests answered directly from IDLE with an error.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned IODEV_BASE_BIT = 29
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [2:0]        mem_we,
  input  logic [31:0]       mem_rdata
);

  // I/O byte stores need no special handling; the RAM decodes the window bit itself.
  if (IODEV_BASE_BIT >= ADDR_W) begin : gen_param_check
    $error("IODEV_BASE_BIT must lie inside the address");
  end

  state_e            state_q;
  logic              store_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       ext_data;
  logic              req_bad;

  assign req_ready = (state_q == StIdle) & rst_n;
  assign req_bad   = is_bad_req(req_store, req_funct3, req_addr[1:0]);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  lsu_extend u_extend (
    .funct3 (funct3_q),
    .raw    (mem_rdata),
    .result (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      store_q    <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      mem_we     <= WE_NONE;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            store_q  <= req_store;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            if (req_bad) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              state_q    <= StResp;
            end else begin
              // Strobe is registered here so it is visible during ISSUE only.
              mem_we  <= req_store ? we_code(req_funct3) : WE_NONE;
              state_q <= StIssue;
            end
          end
        end
        StIssue: begin
          mem_we <= WE_NONE;
          if (store_q) begin
            resp_valid <= 1'b1;
            state_q    <= StResp;
          end else begin
            state_q <= StWait;
          end
        end
        StWait: begin
          resp_rdata <= ext_data;
          resp_valid <= 1'b1;
          state_q    <= StResp;
        end
        StResp: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'd0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
